// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
// Shared definitions for the PUF key majority voter: default key width, the
// voter FSM state encoding and a constant-foldable ceil(log2) helper used to
// size the counters.
// No ports (package).
// -----------------------------------------------------------------------------
package puf_pkg;

    localparam int KEY_W_DEF = 128;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_EN = 3'd1,
        SAMPLE  = 3'd2,
        VOTE    = 3'd3,
        DONE    = 3'd4
    } state_e;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/puf_bit_vote.sv
// -----------------------------------------------------------------------------
// puf_bit_vote
// One key bit's ones-counter plus majority and unanimity compare. The top
// instantiates one of these per key bit.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset (counter -> 0)
//   clr        clear the counter at the next edge (wins over inc_en)
//   inc_en     add bit_in to the counter at the next edge
//   bit_in     raw PUF response bit
//   maj        counter holds more than NUM_SAMPLES/2 ones
//   unanimous  counter is 0 or NUM_SAMPLES (every sample agreed)
// -----------------------------------------------------------------------------
module puf_bit_vote
    import puf_pkg::*;
#(
    parameter int NUM_SAMPLES = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc_en,
    input  logic bit_in,
    output logic maj,
    output logic unanimous
);

    // Wide enough to hold NUM_SAMPLES, so the count can never wrap.
    localparam int CNT_W = clog2(NUM_SAMPLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: assign the hold value first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc_en) begin
            cnt_d = cnt_q + CNT_W'(bit_in);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples its pre-edge inputs together.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign maj       = (cnt_q > CNT_W'(NUM_SAMPLES / 2));
    assign unanimous = (cnt_q == '0) || (cnt_q == CNT_W'(NUM_SAMPLES));

endmodule

// File: rtl/puf_key_voter.sv
// -----------------------------------------------------------------------------
// puf_key_voter
// Samples the ring-oscillator PUF response NUM_SAMPLES times, SAMPLE_GAP cycles
// apart, and presents the per-bit majority as a stable key for the AES key
// schedule. Dropping puf_en mid-sampling aborts and restarts the vote.
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   start         single-cycle pulse requesting a new vote (IDLE/DONE only)
//   puf_key       raw PUF response
//   puf_en        generator ready level
//   key_out       voted key (all ones out of reset)
//   key_valid     key_out is final
//   busy          a vote is in progress
//   unstable_cnt  [PUF_VOTE_STATS_EN only] number of non-unanimous bits in
//                 the last vote
// Build option: define PUF_VOTE_STATS_EN to add the unstable_cnt statistic.
// -----------------------------------------------------------------------------
module puf_key_voter
    import puf_pkg::*;
#(
    parameter int KEY_W       = KEY_W_DEF,
    parameter int NUM_SAMPLES = 5,
    parameter int SAMPLE_GAP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] puf_key,
    input  logic             puf_en,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy
`ifdef PUF_VOTE_STATS_EN
    ,
    output logic [7:0]       unstable_cnt
`endif
);

    localparam int               GAP_W_RAW  = clog2(SAMPLE_GAP);
    localparam int               GAP_W      = (GAP_W_RAW < 1) ? 1 : GAP_W_RAW;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(SAMPLE_GAP - 1);
    localparam logic [3:0]       LAST_SAMP  = 4'(NUM_SAMPLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       samp_cnt_q, samp_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [KEY_W-1:0] key_out_q, key_out_d;
    logic             key_valid_q, key_valid_d;
    logic             busy_q, busy_d;

    logic             clr_cnt;
    logic             inc_en;
    logic             start_ok;
    logic [KEY_W-1:0] maj_w;
    logic [KEY_W-1:0] unan_w;

    // A start pulse is only honoured when no vote is running.
    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

    for (genvar i = 0; i < KEY_W; i++) begin : g_bit
        puf_bit_vote #(
            .NUM_SAMPLES(NUM_SAMPLES)
        ) u_vote (
            .clk      (clk),
            .reset    (reset),
            .clr      (clr_cnt),
            .inc_en   (inc_en),
            .bit_in   (puf_key[i]),
            .maj      (maj_w[i]),
            .unanimous(unan_w[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        samp_cnt_d  = samp_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        key_out_d   = key_out_q;
        key_valid_d = key_valid_q;
        busy_d      = busy_q;
        clr_cnt     = 1'b0;
        inc_en      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // key_out keeps the previous key until the next VOTE.
                if (start_ok) begin
                    state_d     = WAIT_EN;
                    clr_cnt     = 1'b1;
                    samp_cnt_d  = '0;
                    key_valid_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            WAIT_EN: begin
                if (puf_en) begin
                    state_d   = SAMPLE;
                    gap_cnt_d = '0;  // first sample on the first SAMPLE cycle
                end
            end
            SAMPLE: begin
                if (!puf_en) begin
                    // Generator dropped out: discard partial votes and wait again.
                    state_d    = WAIT_EN;
                    clr_cnt    = 1'b1;
                    samp_cnt_d = '0;
                    gap_cnt_d  = '0;
                end else if (gap_cnt_q == '0) begin
                    inc_en     = 1'b1;
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    gap_cnt_d  = GAP_RELOAD;
                    if (samp_cnt_q == LAST_SAMP) begin
                        state_d = VOTE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            VOTE: begin
                key_out_d   = maj_w;
                key_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            samp_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            key_out_q   <= '1;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_cnt_q  <= samp_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            key_out_q   <= key_out_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign key_out   = key_out_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;

`ifdef PUF_VOTE_STATS_EN
    logic [7:0] unstable_q, unstable_d;

    always_comb begin
        unstable_d = unstable_q;
        if (state_q == VOTE) begin
            unstable_d = 8'($countones(~unan_w));
        end else if (start_ok) begin
            unstable_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            unstable_q <= '0;
        end else begin
            unstable_q <= unstable_d;
        end
    end

    assign unstable_cnt = unstable_q;
`else
    // Unanimity flags only feed the statistics counter.
    logic unused_unanimous;
    assign unused_unanimous = ^unan_w;
`endif

endmodule

// File: tb/tb_puf_key_voter.sv
`timescale 1ns/1ps
module tb_puf_key_voter;

    localparam int KW = 128;

    typedef struct packed {
        logic [4:0][KW-1:0] samp;
        logic [KW-1:0]      exp_key;
        logic [7:0]         exp_unst;
    } vec_t;

    typedef struct packed {
        logic [KW-1:0] key;
        logic [7:0]    unst;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          puf_en;
    logic [KW-1:0] puf_key;
    logic [KW-1:0] key_out;
    logic          key_valid;
    logic          busy;

    logic          start_g1;
    logic [7:0]    puf_key_g1;
    logic [7:0]    key_out_g1;
    logic          key_valid_g1;
    logic          busy_g1;
`ifdef PUF_VOTE_STATS_EN
    logic [7:0]    unstable_cnt;
    logic [7:0]    unstable_cnt_g1;
`endif

    vec_t          vecs [7];
    exp_t          sb_q [$];
    logic [7:0]    g1s  [3];
    logic [KW-1:0] prev_key;
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    puf_key_voter #(.KEY_W(KW), .NUM_SAMPLES(5), .SAMPLE_GAP(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .puf_key  (puf_key),
        .puf_en   (puf_en),
        .key_out  (key_out),
        .key_valid(key_valid),
        .busy     (busy)
`ifdef PUF_VOTE_STATS_EN
        ,
        .unstable_cnt(unstable_cnt)
`endif
    );

    // Narrow instance with back-to-back sampling.
    puf_key_voter #(.KEY_W(8), .NUM_SAMPLES(3), .SAMPLE_GAP(1)) dut_g1 (
        .clk      (clk),
        .reset    (reset),
        .start    (start_g1),
        .puf_key  (puf_key_g1),
        .puf_en   (puf_en),
        .key_out  (key_out_g1),
        .key_valid(key_valid_g1),
        .busy     (busy_g1)
`ifdef PUF_VOTE_STATS_EN
        ,
        .unstable_cnt(unstable_cnt_g1)
`endif
    );

    task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [KW-1:0] noise();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic vec_t mk(input logic [KW-1:0] s0, input logic [KW-1:0] s1,
                                input logic [KW-1:0] s2, input logic [KW-1:0] s3,
                                input logic [KW-1:0] s4, input logic [KW-1:0] ek,
                                input logic [7:0] eu);
        vec_t v;
        v.samp[0]  = s0;
        v.samp[1]  = s1;
        v.samp[2]  = s2;
        v.samp[3]  = s3;
        v.samp[4]  = s4;
        v.exp_key  = ek;
        v.exp_unst = eu;
        return v;
    endfunction

    // Pulse start from IDLE/DONE with puf_en high; returns in the first SAMPLE cycle.
    task automatic start_vote(input string tag);
        start   = 1'b1;
        puf_en  = 1'b1;
        puf_key = noise();
        step();
        start = 1'b0;
        check({tag, "_valid_fall"}, key_valid, 1'b0);
        check({tag, "_busy_wait"}, busy, 1'b1);
        check({tag, "_key_kept"}, key_out, prev_key);
`ifdef PUF_VOTE_STATS_EN
        check({tag, "_unst_clr"}, unstable_cnt, 8'd0);
`endif
        step();
    endtask

    // Drive the five samples (noise in the gaps), then wait for and score the result.
    task automatic do_samples(input vec_t v, input int start_k, input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        for (int k = 0; k <= 16; k++) begin
            puf_key = ((k % 4) == 0) ? v.samp[k / 4] : noise();
            start   = (k == start_k);
            if (k == 8) begin
                check({tag, "_busy_mid"}, busy, 1'b1);
                check({tag, "_valid_mid"}, key_valid, 1'b0);
                check({tag, "_key_mid"}, key_out, prev_key);
            end
            if (k == 16) begin
                sb_q.push_back('{key: v.exp_key, unst: v.exp_unst});
            end
            step();
            lat++;
        end
        start   = 1'b0;
        puf_key = noise();
        while (key_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, 18);
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s_scoreboard: queue empty, expected one entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_key"}, key_out, e.key);
            check({tag, "_busy_done"}, busy, 1'b0);
`ifdef PUF_VOTE_STATS_EN
            check({tag, "_unstable"}, unstable_cnt, e.unst);
`endif
        end
        prev_key = v.exp_key;
        step();
        check({tag, "_valid_hold"}, key_valid, 1'b1);
        check({tag, "_key_hold"}, key_out, v.exp_key);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [KW-1:0] c_key, b127, a_hi, b_lo, h_pat;
        int            lat;

        c_key = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        b127  = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
        a_hi  = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        b_lo  = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        h_pat = {8{16'hA5A5}};

        vecs[0] = mk(c_key, c_key, c_key, c_key, c_key, c_key, 8'd0);
        vecs[1] = mk('0, '0, '0, '0, '0, '0, 8'd0);
        vecs[2] = mk(128'h1, b127, 128'h1, '0, b127 | 128'h1, 128'h1, 8'd2);
        vecs[3] = mk(a_hi, a_hi, b_lo, b_lo, a_hi, a_hi, 8'd128);
        vecs[4] = mk(128'hF0, 128'hF0, 128'hF0, 128'h0F, 128'h0F, 128'hF0, 8'd8);
        vecs[5] = mk('0, '0, h_pat, h_pat, h_pat, h_pat, 8'd64);
        vecs[6] = mk('1, '1, '1, '1, '1, '1, 8'd0);
        g1s = '{8'hA5, 8'hC3, 8'h0F};

        reset      = 1'b1;
        start      = 1'b0;
        puf_en     = 1'b0;
        puf_key    = '0;
        start_g1   = 1'b0;
        puf_key_g1 = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_key", key_out, '1);
        check("rst_valid", key_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
`ifdef PUF_VOTE_STATS_EN
        check("rst_unstable", unstable_cnt, 8'd0);
`endif
        prev_key = '1;

        // Table-driven votes; each restarts from IDLE/DONE.
        for (int i = 0; i < 7; i++) begin
            start_vote($sformatf("v%0d", i));
            do_samples(vecs[i], -1, $sformatf("v%0d", i));
        end

        // puf_en drops after the third sample; only post-restart samples count.
        start_vote("ab");
        for (int k = 0; k < 10; k++) begin
            puf_key = ((k % 4) == 0) ? '1 : noise();
            step();
        end
        puf_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            puf_key = noise();
            step();
            check($sformatf("ab_busy_wait%0d", k), busy, 1'b1);
        end
        check("ab_valid_wait", key_valid, 1'b0);
        puf_en = 1'b1;
        step();
        do_samples(mk('0, '0, '0, '0, '0, '0, 8'd0), -1, "ab2");

        // Reset in the middle of SAMPLE, then a start with puf_en low parks in WAIT_EN.
        start_vote("rm");
        for (int k = 0; k < 6; k++) begin
            puf_key = noise();
            step();
        end
        reset = 1'b1;
        step();
        check("rm_key", key_out, '1);
        check("rm_valid", key_valid, 1'b0);
        check("rm_busy", busy, 1'b0);
        reset    = 1'b0;
        prev_key = '1;
        puf_en   = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        check("rm_wait_busy", busy, 1'b1);
        repeat (4) step();
        check("rm_wait_busy_hold", busy, 1'b1);
        check("rm_wait_valid", key_valid, 1'b0);
        puf_en = 1'b1;
        step();
        do_samples(vecs[4], -1, "rm2");

        // start pulse in SAMPLE is ignored: latency and key unchanged.
        start_vote("ss");
        do_samples(vecs[3], 6, "ss");

        // start together with reset: reset wins and the FSM stays in IDLE.
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        check("rs_key", key_out, '1);
        check("rs_valid", key_valid, 1'b0);
        check("rs_busy", busy, 1'b0);
        repeat (3) step();
        check("rs_idle_busy", busy, 1'b0);
        check("rs_idle_valid", key_valid, 1'b0);

        // SAMPLE_GAP=1, NUM_SAMPLES=3: consecutive-cycle sampling, latency 4.
        puf_en   = 1'b1;
        start_g1 = 1'b1;
        step();
        start_g1 = 1'b0;
        check("g1_busy", busy_g1, 1'b1);
        step();
        lat = 0;
        for (int k = 0; k < 3; k++) begin
            puf_key_g1 = g1s[k];
            step();
            lat++;
        end
        puf_key_g1 = 8'hFF;
        while (key_valid_g1 !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("g1_latency", lat, 4);
        check("g1_key", key_out_g1, 8'h87);
        check("g1_busy_done", busy_g1, 1'b0);
`ifdef PUF_VOTE_STATS_EN
        check("g1_unstable", unstable_cnt_g1, 8'd6);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
